// File: rtl/trng_uart_pkg.sv
// Shared types and constants for the TRNG-to-UART frame arbiter.
// Optional checksum byte is enabled by defining TRNG_UART_CHECKSUM_EN.
package trng_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_DONE
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // SYNC + ID + payload bytes, plus the trailing XOR byte when enabled.
   function automatic int frame_bytes(input int data_w);
`ifdef TRNG_UART_CHECKSUM_EN
      return 3 + data_w / 8;
`else
      return 2 + data_w / 8;
`endif
   endfunction

endpackage

// File: rtl/trng_uart_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_SRC-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   int   w_j;
   logic w_found;

   always_comb begin
      grant   = '0;
      idx     = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_j = (int'(last_grant) + k) % NUM_SRC;
         if (!w_found && req[w_j]) begin
            w_found     = 1'b1;
            grant[w_j]  = 1'b1;
            idx         = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/trng_uart_arbiter.sv
// Round-robin shares one UART between NUM_SRC word sources, framing SYNC/ID/DATA.
// Define TRNG_UART_CHECKSUM_EN to append an XOR checksum byte to every frame.
module trng_uart_arbiter
   import trng_uart_pkg::*;
#(
   parameter int          NUM_SRC   = 2,
   parameter int          DATA_W    = 32,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [NUM_SRC-1:0]                            src_valid,
   input  logic [NUM_SRC*DATA_W-1:0]                     src_data,
   output logic [NUM_SRC-1:0]                            src_ready,
   output logic                                          tx_start,
   output logic [7:0]                                    tx_data,
   input  logic                                          tx_busy,
   output logic                                          frame_active,
   output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] grant_id,
   output logic [15:0]                                   frames_sent
);

   localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int DB     = DATA_W / 8;
   localparam int NBYTES = frame_bytes(DATA_W);
   localparam int BI_W   = 4;

   state_t               r_state;
   logic [BI_W-1:0]      r_byte_idx;
   logic [IDX_W-1:0]     r_last_grant;
   logic [DATA_W-1:0]    r_word;
   logic [NUM_SRC-1:0]   w_grant;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_take;
   logic [DATA_W-1:0]    w_sel_data;
   logic [7:0]           w_id_byte;
   logic [7:0]           w_byte;

   rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr (
      .req        (src_valid),
      .last_grant (r_last_grant),
      .grant      (w_grant),
      .idx        (w_idx)
   );

   assign w_take     = (r_state == ST_IDLE) && (|src_valid) && !tx_busy;
   assign w_sel_data = src_data[w_idx*DATA_W +: DATA_W];
   assign w_id_byte  = {{(8-IDX_W){1'b0}}, grant_id};

   // Payload register carries no reset: it is only read after a capture.
   always_ff @(posedge clk) begin
      if (w_take) r_word <= w_sel_data;
   end

`ifdef TRNG_UART_CHECKSUM_EN
   logic [7:0] w_chk;
`endif

   always_comb begin
      w_byte = '0;
`ifdef TRNG_UART_CHECKSUM_EN
      w_chk = SYNC_BYTE ^ w_id_byte;
      for (int i = 0; i < DB; i++) w_chk = w_chk ^ r_word[DATA_W-1-8*i -: 8];
      if (r_byte_idx == BI_W'(DB + 2)) w_byte = w_chk;
`endif
      if (r_byte_idx == BI_W'(0)) w_byte = SYNC_BYTE;
      if (r_byte_idx == BI_W'(1)) w_byte = w_id_byte;
      for (int i = 0; i < DB; i++) begin
         if (r_byte_idx == BI_W'(i + 2)) w_byte = r_word[DATA_W-1-8*i -: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_byte_idx   <= '0;
         r_last_grant <= IDX_W'(NUM_SRC - 1);
         src_ready    <= '0;
         tx_start     <= 1'b0;
         tx_data      <= '0;
         frame_active <= 1'b0;
         grant_id     <= '0;
         frames_sent  <= '0;
      end else begin
         src_ready <= '0;
         tx_start  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  src_ready    <= w_grant;
                  frame_active <= 1'b1;
                  grant_id     <= w_idx;
                  r_byte_idx   <= '0;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tx_data  <= w_byte;
               tx_start <= 1'b1;
               r_state  <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (tx_busy) r_state <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               if (!tx_busy) begin
                  if (r_byte_idx == BI_W'(NBYTES - 1)) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_byte_idx <= r_byte_idx + 1'b1;
                     r_state    <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               frames_sent  <= frames_sent + 16'd1;
               r_last_grant <= grant_id;
               frame_active <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trng_uart_arbiter.sv
// Scoreboard bench for trng_uart_arbiter with a 10-cycle busy UART model.
module tb_trng_uart_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  src_valid = '0;
   logic [63:0] src_data = '0;
   logic [1:0]  src_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        frame_active;
   logic [0:0]  grant_id;
   logic [15:0] frames_sent;

   int          n_checks = 0;
   int          n_fail = 0;
   int          nstart = 0;
   int          busy_cnt;
   logic        ext_busy = 1'b0;
   logic [31:0] srcq0[$];
   logic [31:0] srcq1[$];
   logic [7:0]  exp_b[$];
   int          exp_g[$];

   always #5 clk = ~clk;

   trng_uart_arbiter #(.NUM_SRC(2), .DATA_W(32), .SYNC_BYTE(8'hA5)) dut (
      .clk          (clk),
      .rst          (rst),
      .src_valid    (src_valid),
      .src_data     (src_data),
      .src_ready    (src_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .frame_active (frame_active),
      .grant_id     (grant_id),
      .frames_sent  (frames_sent)
   );

   assign tx_busy = (busy_cnt != 0) || ext_busy;

   always @(posedge clk or posedge rst) begin
      if (rst)                busy_cnt <= 0;
      else if (tx_start)      busy_cnt <= 10;
      else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sources: hold valid while their queue has words, drop a word on src_ready.
   always @(negedge clk) begin
      if (src_ready[0] && srcq0.size() > 0) void'(srcq0.pop_front());
      if (src_ready[1] && srcq1.size() > 0) void'(srcq1.pop_front());
      src_valid[0]    = (srcq0.size() > 0);
      src_valid[1]    = (srcq1.size() > 0);
      src_data[31:0]  = (srcq0.size() > 0) ? srcq0[0] : 32'h0;
      src_data[63:32] = (srcq1.size() > 0) ? srcq1[0] : 32'h0;
   end

   // Monitor: every byte and every grant is matched against the scoreboard.
   always @(negedge clk) begin
      if (tx_start) begin
         nstart++;
         if (exp_b.size() == 0) chk("tx_extra_byte", 32'd1, 32'd0);
         else                   chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_b.pop_front()});
      end
      if (src_ready != 2'b00) begin
         chk("ready_onehot", $countones(src_ready), 32'd1);
         if (exp_g.size() == 0) chk("grant_extra", 32'd1, 32'd0);
         else begin
            int g;
            g = exp_g.pop_front();
            chk("ready_src", {30'h0, src_ready}, 32'(1 << g));
            chk("grant_id", {31'h0, grant_id}, 32'(g));
         end
      end
   end

   task automatic push_frame(input int id, input logic [31:0] w);
      logic [7:0] c;
      c = 8'hA5 ^ 8'(id);
      exp_g.push_back(id);
      exp_b.push_back(8'hA5);
      exp_b.push_back(8'(id));
      for (int i = 0; i < 4; i++) begin
         exp_b.push_back(w[31-8*i -: 8]);
         c = c ^ w[31-8*i -: 8];
      end
`ifdef TRNG_UART_CHECKSUM_EN
      exp_b.push_back(c);
`endif
      if (id == 0) srcq0.push_back(w);
      else         srcq1.push_back(w);
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while ((exp_b.size() != 0 || exp_g.size() != 0 || frame_active) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(t < 5000), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {30'h0, src_ready}, 32'h0);
      chk({tag, "_start"}, {31'h0, tx_start}, 32'h0);
      chk({tag, "_data"}, {24'h0, tx_data}, 32'h0);
      chk({tag, "_active"}, {31'h0, frame_active}, 32'h0);
      chk({tag, "_gid"}, {31'h0, grant_id}, 32'h0);
      chk({tag, "_cnt"}, {16'h0, frames_sent}, 32'h0);
   endtask

   initial begin
      logic bad;
      int   t;
      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      @(negedge clk);

      // 1. Basic frame
      push_frame(0, 32'hDEADBEEF);
      wait_done("t1_done");
      chk("t1_frames", {16'h0, frames_sent}, 32'd1);

      // 2. Simultaneous requests after reset: src0 first, then src1
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      push_frame(0, 32'h11111111);
      push_frame(1, 32'h22222222);
      wait_done("t2_done");
      chk("t2_frames", {16'h0, frames_sent}, 32'd2);

      // 3. src1 pending while src0 streams: grants 0,1,0
      push_frame(0, 32'h01234567);
      push_frame(1, 32'h89ABCDEF);
      push_frame(0, 32'h0F1E2D3C);
      wait_done("t3_done");
      chk("t3_frames", {16'h0, frames_sent}, 32'd5);

      // 4. External busy in IDLE blocks granting
      ext_busy = 1'b1;
      push_frame(0, 32'hCAFEF00D);
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (src_ready != 2'b00 || tx_start) bad = 1'b1;
      end
      chk("t4_hold", {31'h0, bad}, 32'h0);
      chk("t4_pending", {31'h0, frame_active}, 32'h0);
      ext_busy = 1'b0;
      wait_done("t4_done");
      chk("t4_frames", {16'h0, frames_sent}, 32'd6);

      // 5. Reset after the third byte of a frame
      nstart = 0;
      push_frame(1, 32'h55AA55AA);
      t = 0;
      while (nstart < 3 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("t5_reach_byte3", 32'(t < 2000), 32'd1);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("t5_midrst");
      exp_b.delete();
      exp_g.delete();
      srcq0.delete();
      srcq1.delete();
      @(negedge clk);
      rst = 1'b0;
      push_frame(0, 32'h13579BDF);
      push_frame(1, 32'h2468ACE0);
      wait_done("t5_done");
      chk("t5_frames", {16'h0, frames_sent}, 32'd2);

      // 6. Counter wrap
      force dut.frames_sent = 16'hFFFF;
      @(negedge clk);
      release dut.frames_sent;
      @(negedge clk);
      chk("t6_preload", {16'h0, frames_sent}, 32'h0000FFFF);
      push_frame(0, 32'h00C0FFEE);
      wait_done("t6_done");
      chk("t6_wrap", {16'h0, frames_sent}, 32'h0);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
